i2s_sample_transmitter: RTL and testbench

//  Consumer end of the synthesizer's mixed-sample output. Accepts signed 16-bit mono samples

---
 rtl/audio_pkg.sv | 23 ++
 rtl/sample_fifo2.sv | 76 +++++++
 rtl/i2s_sample_transmitter.sv | 157 +++++++++++++++
 tb/tb_i2s_sample_transmitter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------------------------
// audio_pkg
//   Shared types and constants for the synthesizer audio output path.
//   - sample_t            : signed two's complement mono sample
//   - AUDIO_SAMPLE_WIDTH  : bits per sample
//   - I2S_SLOT_WIDTH      : bit clocks per I2S channel slot
//   - I2S_CLK_DIV         : default system clocks per BCLK half-period
//                           (24.576 MHz / (2*4*64) = 48 kHz)
//   - i2s_frame_bits()    : bit clocks in one stereo frame (left + right slot)
// ---------------------------------------------------------------------------------------------
package audio_pkg;

  localparam int unsigned AUDIO_SAMPLE_WIDTH = 16;
  localparam int unsigned I2S_SLOT_WIDTH     = 32;
  localparam int unsigned I2S_CLK_DIV        = 4;

  typedef logic signed [AUDIO_SAMPLE_WIDTH-1:0] sample_t;

  function automatic int unsigned i2s_frame_bits(input int unsigned slot_width);
    return 2 * slot_width;
  endfunction

endpackage

// File: rtl/sample_fifo2.sv
// ---------------------------------------------------------------------------------------------
// sample_fifo2
//   Two-entry synchronous FIFO holding samples between the synthesizer mix and the I2S
//   serialiser. Order is preserved. A push while full or a pop while empty is ignored.
//   A push and a pop in the same cycle at one entry leaves one entry: the new one.
//
// Ports
//   clk       in   system clock, posedge
//   reset_n   in   asynchronous active-low reset; contents discarded
//   i_push    in   write i_data this cycle (ignored when full)
//   i_data    in   sample to write
//   i_pop     in   drop the oldest entry this cycle (ignored when empty)
//   o_data    out  oldest entry (valid when not empty)
//   o_count   out  number of stored entries, 0..2
//   o_full    out  two entries stored
//   o_empty   out  no entries stored
// ---------------------------------------------------------------------------------------------
module sample_fifo2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_data  = r_rd_ptr ? r_mem1 : r_mem0;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) begin
          r_mem1 <= i_data;
        end else begin
          r_mem0 <= i_data;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_transmitter.sv
// ---------------------------------------------------------------------------------------------
// i2s_sample_transmitter
//   Consumer end of the synthesizer's mixed-sample output. Mono samples arrive over a
//   valid/ready handshake into a two-entry buffer; each frame the oldest one is taken and
//   serialised as a standard I2S frame with the same sample on left and right.
//   BCLK and LRCK are derived from the system clock. When the buffer is empty at frame start
//   the previous sample is repeated and an underrun pulse is raised.
//
// Parameters
//   CLK_DIV       system clocks per BCLK half-period (>= 2)
//   SAMPLE_WIDTH  bits per two's complement sample
//   SLOT_WIDTH    BCLKs per channel slot (>= SAMPLE_WIDTH+1)
//
// Ports
//   clk           in   system clock, posedge
//   reset_n       in   asynchronous active-low reset
//   sample_in     in   sample from the synthesizer mix
//   sample_valid  in   sample_in valid this cycle
//   sample_ready  out  buffer has space; a push happens on valid && ready
//   i2s_bclk      out  bit clock
//   i2s_lrck      out  word select, 0 = left slot, 1 = right slot
//   i2s_sdata     out  serial data, MSB first, one BCLK after the LRCK edge
//   frame_start   out  one-clk pulse when a frame's sample is latched
//   underrun      out  one-clk pulse with frame_start when the buffer was empty
// ---------------------------------------------------------------------------------------------
module i2s_sample_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV      = I2S_CLK_DIV,
  parameter int unsigned SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int unsigned SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrck,
  output logic                    i2s_sdata,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int unsigned FRAME_BITS = i2s_frame_bits(SLOT_WIDTH);
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);

  // Clock generation and bit position
  logic [DIV_W-1:0]        r_div;
  logic                    r_bclk;
  logic [BIT_W-1:0]        r_b;

  // Output registers and the sample being played
  logic                    r_lrck;
  logic                    r_sdata;
  logic                    r_frame_start;
  logic                    r_underrun;
  logic [SAMPLE_WIDTH-1:0] r_held;

  logic                    w_div_last;
  logic                    w_fall;
  logic                    w_frame;
  logic [BIT_W-1:0]        w_b_next;
  logic [BIT_W-1:0]        w_p;
  logic                    w_right;
  logic                    w_sdata_next;
  logic [SAMPLE_WIDTH-1:0] w_held_next;

  logic                    w_push;
  logic                    w_pop;
  logic [SAMPLE_WIDTH-1:0] w_fifo_data;
  logic [1:0]              w_fifo_count;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;

  // Ready comes straight from the FIFO occupancy register, so it is valid during reset and
  // never depends on this cycle's pop.
  assign sample_ready = ~w_fifo_full;
  assign w_push       = sample_valid & sample_ready;

  assign w_div_last   = (r_div == DIV_LAST);
  assign w_fall       = w_div_last & r_bclk;
  assign w_frame      = w_fall & (r_b == BIT_LAST);
  assign w_pop        = w_frame & ~w_fifo_empty;

  // The popped sample already drives the frame it opens.
  assign w_held_next  = w_pop ? w_fifo_data : r_held;

  always_comb begin
    w_b_next     = (r_b == BIT_LAST) ? '0 : r_b + 1'b1;
    w_right      = (w_b_next >= SLOT_LEN);
    w_p          = w_right ? (w_b_next - SLOT_LEN) : w_b_next;
    // Position 0 of each slot is the I2S one-BCLK delay; positions past the sample are pad.
    w_sdata_next = 1'b0;
    for (int i = 0; i < int'(SAMPLE_WIDTH); i++) begin
      if (w_p == BIT_W'(int'(SAMPLE_WIDTH) - i)) begin
        w_sdata_next = w_held_next[i];
      end
    end
  end

  sample_fifo2 #(
    .WIDTH (SAMPLE_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (sample_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div         <= '0;
      r_bclk        <= 1'b0;
      r_b           <= BIT_LAST;
      r_lrck        <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_held        <= '0;
    end else begin
      r_div <= w_div_last ? '0 : r_div + 1'b1;
      if (w_div_last) begin
        r_bclk <= ~r_bclk;
      end

      r_frame_start <= w_frame;
      r_underrun    <= w_frame & (w_fifo_count == 2'd0);

      if (w_fall) begin
        r_b     <= w_b_next;
        r_lrck  <= w_right;
        r_sdata <= w_sdata_next;
      end
      if (w_pop) begin
        r_held <= w_fifo_data;
      end
    end
  end

  assign i2s_bclk    = r_bclk;
  assign i2s_lrck    = r_lrck;
  assign i2s_sdata   = r_sdata;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
module tb_i2s_sample_transmitter;
  import audio_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int SW        = 16;
  localparam int SLOT      = 32;
  localparam int FALL      = 2 * CLK_DIV;
  localparam int FRAME_CLK = FALL * 2 * SLOT;

  logic        clk;
  logic        reset_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic        frame_start;
  logic        underrun;

  logic [5:0]  w_obs;
  assign w_obs = {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, sample_ready};

  int tests  = 0;
  int failed = 0;

  // Reference model: clk edges since reset release, queue of buffered samples, held sample
  int          m_n;
  logic [15:0] m_q[$];
  logic [15:0] m_held;
  logic        m_fs;
  logic        m_ur;
  logic        m_push;

  i2s_sample_transmitter #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_WIDTH (SW),
    .SLOT_WIDTH   (SLOT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_frame_edge(input int n);
    return (n > 0) && (n % FALL == 0) && (((n / FALL) - 1) % (2 * SLOT) == 0);
  endfunction

  // Expected {bclk, lrck, sdata, frame_start, underrun, ready} after m_n edges
  function automatic logic [5:0] exp_vec();
    int f, b, p;
    logic bc, lr, sd;
    bc = ((m_n / CLK_DIV) % 2) == 1;
    f  = m_n / FALL;
    lr = 1'b0;
    sd = 1'b0;
    if (f > 0) begin
      b  = (f - 1) % (2 * SLOT);
      p  = b % SLOT;
      lr = (b >= SLOT);
      if (p >= 1 && p <= SW) sd = m_held[4'(SW - p)];
    end
    return {bc, lr, sd, m_fs, m_ur, (m_q.size() < 2)};
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_q.delete();
    m_held = '0;
    m_fs = 1'b0;
    m_ur = 1'b0;
    m_push = 1'b0;
  endtask

  // One clk: advance the model on the posedge, return on the negedge for drive/compare.
  task automatic cycle();
    logic [15:0] d;
    bit          frame;
    @(posedge clk);
    m_push = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else begin
      d      = sample_in;
      m_push = sample_valid && (m_q.size() < 2);
      m_n++;
      frame  = is_frame_edge(m_n);
      m_fs   = frame;
      m_ur   = frame && (m_q.size() == 0);
      if (frame && m_q.size() > 0) m_held = m_q.pop_front();
      if (m_push) m_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests++;
      if (w_obs !== 6'b000001) begin
        failed++;
        $display("FAIL reset_values got %b want %b", w_obs, 6'b000001);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < FRAME_CLK + 100; i++) begin
      cycle();
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL idle n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
      if (m_n == FALL) begin
        tests++;
        if (w_obs[2:1] !== 2'b11) begin
          failed++;
          $display("FAIL idle_first_frame fs/ur got %b want 11", w_obs[2:1]);
        end
      end
    end
  endtask

  task automatic test_push_8001();
    logic [63:0] sd_w, lr_w;
    int          got;
    bit          started, prev_bclk;
    got = 0; started = 0; prev_bclk = i2s_bclk; sd_w = '0; lr_w = '0;
    sample_in = 16'h8001;
    sample_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLK && got < 64; i++) begin
      cycle();
      if (i == 0) sample_valid = 1'b0;
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL push_8001 n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
      if (frame_start) started = 1;
      if (started && (prev_bclk && !i2s_bclk)) begin
        sd_w = {sd_w[62:0], i2s_sdata};
        lr_w = {lr_w[62:0], i2s_lrck};
        got++;
      end
      prev_bclk = i2s_bclk;
    end
    tests++;
    if (got != 64 || sd_w !== 64'h40008000_40008000) begin
      failed++;
      $display("FAIL push_8001_sdata got %h (%0d bits) want %h", sd_w, got, 64'h40008000_40008000);
    end
    tests++;
    if (lr_w !== 64'h00000000_FFFFFFFF) begin
      failed++;
      $display("FAIL push_8001_lrck got %h want %h", lr_w, 64'h00000000_FFFFFFFF);
    end
  endtask

  task automatic test_back_to_back();
    sample_t vals[3];
    bit      done;
    vals = '{16'sh1234, 16'sh5678, -16'sh6544};  // -0x6544 == 16'h9ABC
    for (int k = 0; k < 3; k++) begin
      sample_in = vals[k];
      sample_valid = 1'b1;
      done = 0;
      for (int i = 0; i < 2 * FRAME_CLK && !done; i++) begin
        cycle();
        tests++;
        if (w_obs !== exp_vec()) begin
          failed++;
          $display("FAIL b2b n=%0d got %b want %b", m_n, w_obs, exp_vec());
        end
        if (k == 2 && i == 0 && !m_push) begin
          tests++;
          if (sample_ready !== 1'b0) begin
            failed++;
            $display("FAIL b2b_ready_full got %b want 0", sample_ready);
          end
        end
        done = m_push;
      end
      sample_valid = 1'b0;
      tests++;
      if (!done) begin
        failed++;
        $display("FAIL b2b_accept k=%0d not accepted within %0d clk", k, 2 * FRAME_CLK);
      end
    end
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      cycle();
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL b2b_drain n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_starve();
    int nfs;
    nfs = 0;
    sample_in = 16'h1357;
    sample_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLK && nfs < 3; i++) begin
      cycle();
      if (m_push) sample_valid = 1'b0;
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL starve n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
      if (frame_start) begin
        nfs++;
        if (nfs == 2) begin
          sample_in = 16'h2468;
          sample_valid = 1'b1;
        end
        tests++;
        if (underrun !== (nfs == 2)) begin
          failed++;
          $display("FAIL starve_underrun frame %0d got %b want %b", nfs, underrun, nfs == 2);
        end
      end
    end
    sample_valid = 1'b0;
    tests++;
    if (nfs < 3) begin
      failed++;
      $display("FAIL starve_frames got %0d frame starts want 3", nfs);
    end
  endtask

  task automatic test_push_at_frame();
    bit reached;
    reached = 0;
    for (int i = 0; i < 2 * FRAME_CLK && m_q.size() != 0; i++) cycle();
    sample_in = 16'h0F0F;
    sample_valid = 1'b1;
    for (int i = 0; i < FRAME_CLK + 10 && !reached; i++) begin
      cycle();
      if (m_push) sample_valid = 1'b0;
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL push_at_frame n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
      reached = is_frame_edge(m_n + 1) && (m_q.size() == 1) && !sample_valid;
    end
    sample_in = 16'hD00D;
    sample_valid = 1'b1;
    cycle();
    sample_valid = 1'b0;
    tests++;
    if (!reached || w_obs[2:0] !== 3'b101) begin
      failed++;
      $display("FAIL push_at_frame_edge fs/ur/ready got %b want 101", w_obs[2:0]);
    end
    for (int i = 0; i < FRAME_CLK + 100; i++) begin
      cycle();
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL push_at_frame_after n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FRAME_CLK; i++) begin
      if (!sample_valid && $urandom_range(0, 299) == 0) begin
        sample_in = 16'($urandom);
        sample_valid = 1'b1;
      end
      cycle();
      if (m_push) sample_valid = 1'b0;
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL random n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit in_right;
    in_right = 0;
    sample_in = 16'($urandom);
    sample_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLK && !in_right; i++) begin
      cycle();
      if (m_push) sample_valid = 1'b0;
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL reset_mid_pre n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
      in_right = exp_vec()[4] && !sample_valid && ((m_n / FALL - 1) % (2 * SLOT) >= SLOT + 8);
    end
    sample_in = 16'hFFFF;
    sample_valid = 1'b1;
    reset_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (!in_right || w_obs !== 6'b000001) begin
      failed++;
      $display("FAIL reset_mid_async got %b want %b", w_obs, 6'b000001);
    end
    for (int i = 0; i < 3; i++) cycle();
    sample_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < FRAME_CLK + 100; i++) begin
      cycle();
      tests++;
      if (w_obs !== exp_vec()) begin
        failed++;
        $display("FAIL reset_mid_post n=%0d got %b want %b", m_n, w_obs, exp_vec());
      end
      if (m_n == FALL) begin
        tests++;
        if (w_obs[2:1] !== 2'b11) begin
          failed++;
          $display("FAIL reset_mid_first_frame fs/ur got %b want 11", w_obs[2:1]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    model_reset();
    test_reset();
    test_idle();
    test_push_8001();
    test_back_to_back();
    test_starve();
    test_push_at_frame();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
